// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared state encoding and memory-map constants for the data-memory responder
package dmem_responder_pkg;

    // Responder handshake phases: accept, latency wait, response hold.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Read data returned for stores, out-of-range accesses and idle cycles.
    localparam logic [31:0] RESP_DATA_ERR = 32'h0;

    // Default byte address of word 0; the core's PC reset value uses the same constant.
    localparam logic [31:0] BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with synchronous byte-lane writes and combinational read
module dmem_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wmask,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Only lanes with their mask bit set are updated; contents are never reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store data-memory slave with valid/ready channels and fixed access latency
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = dmem_responder_pkg::BASE_ADDR,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;

    logic          cap_wen;
    logic          cap_inr;
    logic [AW-1:0] cap_idx;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_wmask;

    logic          resp_valid_n;
    logic [31:0]   resp_rdata_n;
    logic          resp_err_n;

    logic [32:0]   offset;
    logic          req_inr;
    logic [AW-1:0] req_idx;
    logic          accept;
    logic          commit;

    logic          acc_wen;
    logic          acc_inr;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_wmask;

    logic          arr_wen;
    logic [31:0]   arr_rdata;

    // 33-bit offset: an address below the base wraps to a huge value and fails the span test.
    assign offset    = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign req_inr   = (offset < SPAN);
    assign req_idx   = offset[AW+1:2];
    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;

    // With single-cycle latency the access happens on the accept edge, so it uses the live request.
    always_comb begin
        acc_wen   = cap_wen;
        acc_inr   = cap_inr;
        acc_idx   = cap_idx;
        acc_wdata = cap_wdata;
        acc_wmask = cap_wmask;
        if (state == ST_IDLE) begin
            acc_wen   = req_wen;
            acc_inr   = req_inr;
            acc_idx   = req_idx;
            acc_wdata = req_wdata;
            acc_wmask = req_wmask;
        end
    end

    // Next state, latency counter and the registered response fields.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        commit       = 1'b0;
        resp_valid_n = resp_valid;
        resp_rdata_n = resp_rdata;
        resp_err_n   = resp_err;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        commit  = 1'b1;
                        state_n = ST_RESP;
                    end else begin
                        cnt_n   = LAT_M1;
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    commit  = 1'b1;
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_n = 1'b0;
                    resp_rdata_n = RESP_DATA_ERR;
                    resp_err_n   = 1'b0;
                    state_n      = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (commit) begin
            resp_valid_n = 1'b1;
            resp_err_n   = ~acc_inr;
            resp_rdata_n = (acc_inr && !acc_wen) ? arr_rdata : RESP_DATA_ERR;
        end
    end

    // A reset on the commit edge suppresses the write, so the store is dropped.
    assign arr_wen = commit & acc_inr & acc_wen & ~rst;

    // State, counter, request capture and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= RESP_DATA_ERR;
            resp_err   <= 1'b0;
            cap_wen    <= 1'b0;
            cap_inr    <= 1'b0;
            cap_idx    <= '0;
            cap_wdata  <= 32'h0;
            cap_wmask  <= 4'h0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
            if (accept) begin
                cap_wen   <= req_wen;
                cap_inr   <= req_inr;
                cap_idx   <= req_idx;
                cap_wdata <= req_wdata;
                cap_wmask <= req_wmask;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .wen  (arr_wen),
        .addr (acc_idx),
        .wdata(acc_wdata),
        .wmask(acc_wmask),
        .rdata(arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at latencies 2 and 1
module tb_dmem_responder;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic              req_wen;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wmask;
    logic              resp_ready;
    logic [1:0]        req_ready_w;
    logic [1:0]        resp_valid_w;
    logic [1:0]        resp_err_w;
    logic [1:0][31:0]  rdata_w;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready_w[0]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid_w[0]), .resp_ready(resp_ready), .resp_rdata(rdata_w[0]),
        .resp_err(resp_err_w[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready_w[1]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid_w[1]), .resp_ready(resp_ready), .resp_rdata(rdata_w[1]),
        .resp_err(resp_err_w[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Behavioural model: per-responder memory image and the single outstanding transaction.
    logic [31:0] mmem [2][DEPTH];
    bit          armed [2];
    bit          busy  [2];
    int          age   [2];
    bit          m_wen [2];
    bit          m_inr [2];
    int          m_idx [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_mask [2];
    logic [31:0] exp_data [2];
    logic        exp_err [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            armed[d] = 0;
            busy[d]  = 0;
            for (int i = 0; i < DEPTH; i++) mmem[d][i] = 32'h0;
        end
    end

    task automatic model_commit(input int d);
        if (m_wen[d] && m_inr[d]) begin
            for (int b = 0; b < 4; b++) begin
                if (m_mask[d][b]) mmem[d][m_idx[d]][8*b +: 8] = m_wdata[d][8*b +: 8];
            end
        end
    endtask

    // Compare every cycle against the model, then advance the model by the inputs the next edge samples.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (armed[d]) begin
                if (!busy[d]) begin
                    chk($sformatf("d%0d_idle_req_ready", d), {31'h0, req_ready_w[d]}, 32'd1);
                    chk($sformatf("d%0d_idle_resp_valid", d), {31'h0, resp_valid_w[d]}, 32'd0);
                    chk($sformatf("d%0d_idle_rdata", d), rdata_w[d], 32'h0);
                    chk($sformatf("d%0d_idle_err", d), {31'h0, resp_err_w[d]}, 32'd0);
                end else if (age[d] < lat_of(d)) begin
                    chk($sformatf("d%0d_wait_req_ready", d), {31'h0, req_ready_w[d]}, 32'd0);
                    chk($sformatf("d%0d_wait_resp_valid", d), {31'h0, resp_valid_w[d]}, 32'd0);
                end else begin
                    chk($sformatf("d%0d_resp_req_ready", d), {31'h0, req_ready_w[d]}, 32'd0);
                    chk($sformatf("d%0d_resp_valid", d), {31'h0, resp_valid_w[d]}, 32'd1);
                    chk($sformatf("d%0d_resp_rdata", d), rdata_w[d], exp_data[d]);
                    chk($sformatf("d%0d_resp_err", d), {31'h0, resp_err_w[d]}, {31'h0, exp_err[d]});
                end
            end
            if (rst) begin
                armed[d] = 1;
                busy[d]  = 0;
            end else if (armed[d]) begin
                if (!busy[d]) begin
                    if (req_valid[d]) begin
                        longint off;
                        off        = longint'(req_addr) - longint'(BASE);
                        m_inr[d]   = (off >= 0) && (off < 4 * DEPTH);
                        m_idx[d]   = m_inr[d] ? int'(off / 4) : 0;
                        m_wen[d]   = req_wen;
                        m_wdata[d] = req_wdata;
                        m_mask[d]  = req_wmask;
                        exp_err[d] = !m_inr[d];
                        exp_data[d] = (m_inr[d] && !req_wen) ? mmem[d][m_idx[d]] : 32'h0;
                        busy[d] = 1;
                        age[d]  = 1;
                        if (lat_of(d) == 1) model_commit(d);
                    end
                end else if (age[d] < lat_of(d)) begin
                    age[d]++;
                    if (age[d] == lat_of(d)) model_commit(d);
                end else if (resp_ready) begin
                    busy[d] = 0;
                end
            end
        end
    end

    task automatic xact(input int d, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
        bit ok;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        if (hold > 0) resp_ready = 1'b0;
        req_valid[d] = 1'b1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready_w[d];
        end
        if (!ok) timeout("accept");
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 0;
        ok  = 0;
        while (!ok && lat < 20) begin
            @(negedge clk);
            lat++;
            ok = resp_valid_w[d];
        end
        if (!ok) timeout("response");
        rdata = rdata_w[d];
        err   = resp_err_w[d];
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pat [8];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          t, tprev;
        bit          ok;

        pat[0] = 32'h0123_4567; pat[1] = 32'h89AB_CDEF; pat[2] = 32'hFFFF_FFFF; pat[3] = 32'h0000_0001;
        pat[4] = 32'h8000_0000; pat[5] = 32'h5A5A_5A5A; pat[6] = 32'hA5A5_A5A5; pat[7] = 32'h0F0F_0F0F;

        rst        = 1'b1;
        req_valid  = 2'b01;
        req_wen    = 1'b1;
        req_addr   = 32'h8000_0010;
        req_wdata  = 32'hFFFF_FFFF;
        req_wmask  = 4'hF;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("reset_req_ready", {31'h0, req_ready_w[0]}, 32'd1);
        chk("reset_resp_valid", {31'h0, resp_valid_w[0]}, 32'd0);
        chk("reset_rdata", rdata_w[0], 32'h0);
        chk("reset_err", {31'h0, resp_err_w[0]}, 32'd0);
        @(posedge clk);
        #1;

        xact(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
        chk("store_latency", lat, 32'd2);
        chk("store_rdata", rd, 32'h0);
        chk("store_err", {31'h0, er}, 32'd0);
        xact(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
        chk("load_latency", lat, 32'd2);
        chk("load_rdata", rd, 32'hDEAD_BEEF);
        chk("load_err", {31'h0, er}, 32'd0);

        xact(0, 1'b1, 32'h8000_0014, 32'h1122_3344, 4'hF, 0, rd, er, lat);
        xact(0, 1'b1, 32'h8000_0014, 32'h0000_AA00, 4'b0010, 0, rd, er, lat);
        xact(0, 1'b0, 32'h8000_0014, 32'h0, 4'h0, 0, rd, er, lat);
        chk("partial_store", rd, 32'h1122_AA44);
        xact(0, 1'b1, 32'h8000_0014, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lat);
        xact(0, 1'b0, 32'h8000_0014, 32'h0, 4'h0, 0, rd, er, lat);
        chk("mask0_noop", rd, 32'h1122_AA44);

        xact(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd, er, lat);
        chk("below_base_err", {31'h0, er}, 32'd1);
        chk("below_base_rdata", rd, 32'h0);
        xact(0, 1'b0, 32'h8000_4000, 32'h0, 4'h0, 0, rd, er, lat);
        chk("above_top_err", {31'h0, er}, 32'd1);
        chk("above_top_rdata", rd, 32'h0);
        xact(0, 1'b0, 32'h8000_3FFC, 32'h0, 4'h0, 0, rd, er, lat);
        chk("last_word_err", {31'h0, er}, 32'd0);
        xact(0, 1'b1, 32'h8000_0000, 32'h55AA_55AA, 4'hF, 0, rd, er, lat);
        xact(0, 1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, 0, rd, er, lat);
        chk("oor_store_err", {31'h0, er}, 32'd1);
        xact(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er, lat);
        chk("word0_untouched", rd, 32'h55AA_55AA);

        xact(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, rd, er, lat);
        chk("hold_rdata", rd, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("hold_req_ready_after", {31'h0, req_ready_w[0]}, 32'd1);
        @(posedge clk);
        #1;

        xact(0, 1'b1, 32'h8000_0020, 32'h0, 4'hF, 0, rd, er, lat);
        req_wen      = 1'b1;
        req_addr     = 32'h8000_0020;
        req_wdata    = 32'hCAFE_F00D;
        req_wmask    = 4'hF;
        req_valid[0] = 1'b1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready_w[0];
        end
        if (!ok) timeout("reset_accept");
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_resp_valid", {31'h0, resp_valid_w[0]}, 32'd0);
        chk("midreset_req_ready", {31'h0, req_ready_w[0]}, 32'd1);
        @(posedge clk);
        #1;
        xact(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er, lat);
        chk("dropped_store", rd, 32'h0);

        for (int i = 0; i < 8; i++) begin
            xact(1, 1'b1, 32'h8000_0100 + 32'(4 * i), pat[i], 4'hF, 0, rd, er, lat);
            if (i == 0) chk("lat1_latency", lat, 32'd1);
        end
        req_wen      = 1'b0;
        req_valid[1] = 1'b1;
        tprev = 0;
        for (int i = 0; i < 8; i++) begin
            req_addr = 32'h8000_0100 + 32'(4 * i);
            ok = 0;
            for (int n = 0; n < 20 && !ok; n++) begin
                @(negedge clk);
                ok = req_ready_w[1];
            end
            if (!ok) timeout("b2b_accept");
            @(posedge clk);
            #1;
            t = cyc;
            if (i > 0) chk("b2b_spacing", t - tprev, 32'd2);
            tprev = t;
            @(negedge clk);
            chk("b2b_valid", {31'h0, resp_valid_w[1]}, 32'd1);
            chk("b2b_rdata", rdata_w[1], pat[i]);
            @(posedge clk);
            #1;
        end
        req_valid[1] = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
